relogio_ctrl: RTL
=================

Name: relogio_ctrl

Overview:
Mode controller and increment scheduler for the clock's hour and minute counters. It decides whether the clock runs or is being set, routes user increments and the minute counter's carry to the hour counter as single-cycle pulses, and returns to run mode after a period with no button activity. It sits between the debounced button inputs and the 1 Hz tick on one side, and the seconds, minutes and hours counters and the display on the other.

Parameters:
TIMEOUT_TICKS, 10, number of 1 Hz ticks with no button edge after which a set mode exits to RUN; must be at least 1.
TO_W, 4, width of the timeout counter; must satisfy 2**TO_W > TIMEOUT_TICKS.

Ports:
clk_i  in  1  system clock, all logic on its rising edge
rst_i  in  1  asynchronous reset, active-high
tick_i  in  1  1 Hz strobe, one clk_i cycle wide
btn_mode_i  in  1  mode button, synchronized and debounced level
btn_inc_i  in  1  increment button, synchronized and debounced level
carry_min_i  in  1  minute-counter wrap pulse (59->0), one cycle wide
mode_o  out  2  current mode: 00 RUN, 01 SET_HORA, 10 SET_MIN
run_o  out  1  seconds-counter enable, 1 only in RUN
inc_min_o  out  1  one-cycle increment pulse to the minutes counter
inc_hora_o  out  1  one-cycle increment pulse to the hours counter (its inc_hora_i)
clr_seg_o  out  1  one-cycle pulse that clears the seconds counter
blink_o  out  1  display blank/show control for the digit being set

Behaviour:
- The clock is one domain, clk_i. Reset is asynchronous and active-high (rst_i). All outputs are registered.
- Reset values: mode_o=00 (RUN), run_o=1, inc_min_o=0, inc_hora_o=0, clr_seg_o=0, blink_o=0. The timeout counter resets to 0. Both button edge-detect registers reset to 1, so a button held through reset produces no edge.
- Edge detect: an edge is the input at 1 with its previous-cycle sample at 0. Only rising edges act. A held button gives exactly one edge.
- State machine:
  - RUN -> SET_HORA on a mode edge.
  - SET_HORA -> SET_MIN on a mode edge.
  - SET_MIN -> RUN on a mode edge.
  - SET_HORA or SET_MIN -> RUN on timeout.
  - Every transition into RUN pulses clr_seg_o for one cycle, in the same cycle mode_o becomes 00.
  - No other transitions exist. Encoding 11 is unreachable; if it is ever reached, the next state is RUN.
- run_o: registered, equals (next state == RUN). It drops in the same cycle mode_o leaves 00.
- Increment routing (all outputs registered, so 1-cycle latency from the sampled cause):
  - inc_hora_o = (state RUN and carry_min_i) or (state SET_HORA and inc edge).
  - inc_min_o = (state SET_MIN and inc edge).
  - carry_min_i is dropped in SET_HORA and SET_MIN, so minutes wrap during setting without touching hours.
  - Inc edges in RUN are ignored.
  - Routing uses the current state, not the next state. An inc edge in the same cycle as a mode edge applies to the mode being left.
- Timeout counter:
  - Cleared on entry to a set mode and on any mode or inc edge while in a set mode.
  - Otherwise increments on tick_i while in a set mode.
  - When tick_i arrives with count == TIMEOUT_TICKS-1, the next state is RUN.
  - A button edge in the same cycle as the timeout tick wins: the counter clears and no timeout occurs.
  - The counter holds at 0 in RUN.
- blink_o:
  - 0 in RUN.
  - Set to 1 on entry to a set mode and on each inc edge.
  - Otherwise toggles on each tick_i while in a set mode.
- Simultaneous mode and inc edges: both are processed in the same cycle as described above. Neither is lost or deferred.
- Reset mid-operation: any pulse in flight is forced to 0 immediately, the state goes to RUN, and no clr_seg_o pulse is generated by reset.

Test Plan:
1. Reset behaviour: hold btn_mode_i=1 through reset, release rst_i -> mode_o stays 00 and run_o=1 with no edge. Then btn_mode_i 0->1 -> mode_o=01 next cycle, run_o=0.
2. Mode cycling: three mode edges spaced 5 cycles apart -> mode_o sequence 01, 10, 00. clr_seg_o is high exactly one cycle, coincident with mode_o returning to 00.
3. Hour routing: in SET_HORA, btn_inc_i held high for 20 cycles -> exactly one inc_hora_o pulse, one cycle after the edge, and inc_min_o stays 0. In RUN, a carry_min_i pulse -> inc_hora_o pulse one cycle later.
4. Carry suppression: in SET_MIN, inc edge and carry_min_i in the same cycle -> one inc_min_o pulse and no inc_hora_o.
5. Timeout: enter SET_HORA, apply 10 ticks with no buttons (TIMEOUT_TICKS=10) -> return to RUN on the cycle after the 10th tick, with a clr_seg_o pulse. Repeat with an inc edge coincident with the 10th tick -> mode_o stays 01 and the counter restarts.
6. Async reset mid-pulse: assert rst_i in the cycle inc_hora_o=1 -> inc_hora_o=0 and mode_o=00 before the next clk_i edge. blink_o goes from toggling to 0.

Source files
------------

// File: rtl/relogio_ctrl.sv
// relogio_ctrl: run/set mode FSM for the clock, routing of hour/minute increment pulses,
// inactivity timeout back to RUN and digit blink control.
module relogio_ctrl #(
    parameter int unsigned TIMEOUT_TICKS = 10,
    parameter int unsigned TO_W          = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tick_i,
    input  logic       btn_mode_i,
    input  logic       btn_inc_i,
    input  logic       carry_min_i,
    output logic [1:0] mode_o,
    output logic       run_o,
    output logic       inc_min_o,
    output logic       inc_hora_o,
    output logic       clr_seg_o,
    output logic       blink_o
);

    typedef enum logic [1:0] {
        StRun     = 2'b00,
        StSetHora = 2'b01,
        StSetMin  = 2'b10
    } state_e;

    state_e            state_q, state_d;
    logic              mode_prev_q, inc_prev_q;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              run_q, run_d;
    logic              inc_min_q, inc_min_d;
    logic              inc_hora_q, inc_hora_d;
    logic              clr_seg_q, clr_seg_d;
    logic              blink_q, blink_d;

    logic mode_edge, inc_edge, in_set, timeout, entering;

    assign mode_edge = btn_mode_i & ~mode_prev_q;
    assign inc_edge  = btn_inc_i & ~inc_prev_q;
    assign in_set    = (state_q == StSetHora) || (state_q == StSetMin);
    // A button edge on the final tick keeps the set mode alive.
    assign timeout   = in_set && tick_i && !mode_edge && !inc_edge &&
                       (to_cnt_q == TO_W'(TIMEOUT_TICKS - 1));

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun:     if (mode_edge) state_d = StSetHora;
            StSetHora: begin
                if (mode_edge)    state_d = StSetMin;
                else if (timeout) state_d = StRun;
            end
            StSetMin:  if (mode_edge || timeout) state_d = StRun;
            default:   state_d = StRun;
        endcase
    end

    assign entering = (state_d != state_q);

    always_comb begin
        run_d      = (state_d == StRun);
        clr_seg_d  = (state_d == StRun) && (state_q != StRun);
        inc_hora_d = ((state_q == StRun) && carry_min_i) ||
                     ((state_q == StSetHora) && inc_edge);
        inc_min_d  = (state_q == StSetMin) && inc_edge;

        to_cnt_d = to_cnt_q;
        if (state_d == StRun || entering || mode_edge || inc_edge) begin
            to_cnt_d = '0;
        end else if (tick_i) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end

        blink_d = blink_q;
        if (state_d == StRun) begin
            blink_d = 1'b0;
        end else if (entering || inc_edge) begin
            blink_d = 1'b1;
        end else if (tick_i) begin
            blink_d = ~blink_q;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= StRun;
            mode_prev_q <= 1'b1;
            inc_prev_q  <= 1'b1;
            to_cnt_q    <= '0;
            run_q       <= 1'b1;
            inc_min_q   <= 1'b0;
            inc_hora_q  <= 1'b0;
            clr_seg_q   <= 1'b0;
            blink_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_prev_q <= btn_mode_i;
            inc_prev_q  <= btn_inc_i;
            to_cnt_q    <= to_cnt_d;
            run_q       <= run_d;
            inc_min_q   <= inc_min_d;
            inc_hora_q  <= inc_hora_d;
            clr_seg_q   <= clr_seg_d;
            blink_q     <= blink_d;
        end
    end

    assign mode_o     = state_q;
    assign run_o      = run_q;
    assign inc_min_o  = inc_min_q;
    assign inc_hora_o = inc_hora_q;
    assign clr_seg_o  = clr_seg_q;
    assign blink_o    = blink_q;

endmodule
